// File: rtl/uart_pkg.sv
// Shared definitions for the uart receive-side buffer: capture FSM encoding
// and default FIFO geometry / flow-control watermarks.
package uart_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    ACK  = 1'b1
  } cap_state_t;

  localparam int unsigned DEF_DEPTH_LOG2 = 4;
  localparam int unsigned DEF_HIWATER    = 12;
  localparam int unsigned DEF_LOWATER    = 4;

endpackage

// File: rtl/uart_fifo_mem.sv
// FIFO storage: one synchronous write port, one asynchronous read port
// (distributed-RAM style, contents not reset).
module uart_fifo_mem #(
  parameter int unsigned DEPTH_LOG2 = 4,
  parameter int unsigned WIDTH      = 8
) (
  input  logic                  clk,
  input  logic                  we,
  input  logic [DEPTH_LOG2-1:0] waddr,
  input  logic [WIDTH-1:0]      wdata,
  input  logic [DEPTH_LOG2-1:0] raddr,
  output logic [WIDTH-1:0]      rdata
);

  logic [WIDTH-1:0] mem [2**DEPTH_LOG2];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/uart_rx_fifo.sv
// Receive buffer behind uart_rx: captures acknowledged bytes into a FWFT FIFO.
// Optional hysteretic rts_hold output is built when UART_RX_FIFO_RTS_EN is defined.
module uart_rx_fifo
  import uart_pkg::*;
#(
  parameter int unsigned DEPTH_LOG2 = DEF_DEPTH_LOG2,
  parameter int unsigned HIWATER    = DEF_HIWATER,
  parameter int unsigned LOWATER    = DEF_LOWATER
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [7:0]            rx_data,
  input  logic                  rx_recv,
  output logic                  rx_read,
  input  logic                  cpu_rd,
  output logic [7:0]            cpu_data,
  output logic                  cpu_avail,
  output logic                  full,
  output logic [DEPTH_LOG2:0]   level,
  output logic                  rts_hold
);

  localparam int unsigned         DEPTH     = 2**DEPTH_LOG2;
  localparam logic [DEPTH_LOG2:0] DEPTH_LVL = DEPTH[DEPTH_LOG2:0];

  cap_state_t            state;
  logic [DEPTH_LOG2-1:0] wr_ptr;
  logic [DEPTH_LOG2-1:0] rd_ptr;
  logic                  push;
  logic                  pop;

  assign full      = (level == DEPTH_LVL);
  assign cpu_avail = (level != '0);
  assign push      = (state == IDLE) && rx_recv && !full;
  assign pop       = cpu_rd && cpu_avail;

  // ACK waits for rx_recv to drop so a still-asserted request is not captured twice.
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      rx_read <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          rx_read <= push;
          if (push) state <= ACK;
        end
        ACK: begin
          rx_read <= 1'b0;
          if (!rx_recv) state <= IDLE;
        end
        default: begin
          rx_read <= 1'b0;
          state   <= IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   level <= level + 1'b1;
        2'b01:   level <= level - 1'b1;
        default: level <= level;
      endcase
    end
  end

  uart_fifo_mem #(
    .DEPTH_LOG2 (DEPTH_LOG2),
    .WIDTH      (8)
  ) u_mem (
    .clk   (clk),
    .we    (push),
    .waddr (wr_ptr),
    .wdata (rx_data),
    .raddr (rd_ptr),
    .rdata (cpu_data)
  );

`ifdef UART_RX_FIFO_RTS_EN
  localparam logic [DEPTH_LOG2:0] HI_LVL = HIWATER[DEPTH_LOG2:0];
  localparam logic [DEPTH_LOG2:0] LO_LVL = LOWATER[DEPTH_LOG2:0];

  if (LOWATER >= HIWATER || HIWATER > DEPTH) begin : g_bad_watermarks
    $error("uart_rx_fifo: need LOWATER < HIWATER <= 2**DEPTH_LOG2");
  end

  always_ff @(posedge clk) begin
    if (rst)                  rts_hold <= 1'b0;
    else if (level >= HI_LVL) rts_hold <= 1'b1;
    else if (level <= LO_LVL) rts_hold <= 1'b0;
  end
`else
  logic unused_watermarks;
  assign unused_watermarks = ^{HIWATER, LOWATER};
  assign rts_hold = 1'b0;
`endif

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Scoreboard bench for uart_rx_fifo with a behavioural uart_rx handshake model.
module tb_uart_rx_fifo;

`ifdef UART_RX_FIFO_RTS_EN
  localparam logic RTS_EN = 1'b1;
`else
  localparam logic RTS_EN = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] rx_data;
  logic       rx_recv;
  logic       rx_read;
  logic       cpu_rd;
  logic [7:0] cpu_data;
  logic       cpu_avail;
  logic       full;
  logic [4:0] level;
  logic       rts_hold;

  uart_rx_fifo #(
    .DEPTH_LOG2 (4),
    .HIWATER    (12),
    .LOWATER    (4)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .rx_data   (rx_data),
    .rx_recv   (rx_recv),
    .rx_read   (rx_read),
    .cpu_rd    (cpu_rd),
    .cpu_data  (cpu_data),
    .cpu_avail (cpu_avail),
    .full      (full),
    .level     (level),
    .rts_hold  (rts_hold)
  );

  always #5 clk = ~clk;

  int unsigned n_chk  = 0;
  int unsigned n_fail = 0;
  logic [7:0]  rx_q[$];
  logic [7:0]  sb[$];
  int unsigned hold_extra = 1;
  int unsigned ack_cnt = 0;
  logic        track = 1'b0;
  int unsigned max_lvl = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: every accepted pop is checked against the scoreboard head.
  always @(negedge clk) begin
    if (rx_read) ack_cnt++;
    if (track && level > max_lvl) max_lvl = level;
    if (!rst && cpu_rd && cpu_avail) begin
      if (sb.size() == 0) begin
        n_chk++;
        n_fail++;
        $display("FAIL sb_underflow: got %0h expected none", cpu_data);
      end else begin
        chk("pop_data", {24'b0, cpu_data}, {24'b0, sb.pop_front()});
      end
    end
  end

  // Receiver model: presents a byte, drops rx_recv hold_extra cycles after rx_read.
  initial begin
    int unsigned w;
    rx_recv = 1'b0;
    rx_data = '0;
    forever begin
      @(posedge clk); #1;
      if (rx_q.size() > 0 && !rst) begin
        rx_data = rx_q[0];
        rx_recv = 1'b1;
        w = 0;
        do begin
          @(posedge clk); #1;
          w++;
        end while (!rx_read && w < 300);
        if (!rx_read) chk("rx_ack_timeout", 32'(rx_read), 32'd1);
        repeat (hold_extra) @(posedge clk);
        #1;
        rx_recv = 1'b0;
        void'(rx_q.pop_front());
      end
    end
  end

  task automatic put(input logic [7:0] b);
    rx_q.push_back(b);
    sb.push_back(b);
  endtask

  task automatic wait_idle();
    int unsigned c = 0;
    while ((rx_q.size() != 0 || rx_recv) && c < 500) begin
      @(posedge clk); #1;
      c++;
    end
    if (c >= 500) chk("idle_timeout", 32'(rx_q.size()), 32'd0);
    @(posedge clk); #1;
  endtask

  task automatic pop_n(input int unsigned n);
    @(posedge clk); #1;
    cpu_rd = 1'b1;
    repeat (n) @(posedge clk);
    #1;
    cpu_rd = 1'b0;
  endtask

  task automatic direct_push(input logic [7:0] b, input logic rd);
    @(posedge clk); #1;
    rx_data = b;
    rx_recv = 1'b1;
    cpu_rd  = rd;
    sb.push_back(b);
    @(posedge clk); #1;
    cpu_rd = 1'b0;
    chk("direct_ack", 32'(rx_read), 32'd1);
  endtask

  task automatic direct_release();
    @(posedge clk); #1;
    rx_recv = 1'b0;
    @(posedge clk); #1;
  endtask

  initial begin
    int unsigned occ;
    int unsigned acks;
    rst    = 1'b1;
    cpu_rd = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    chk("rst_rx_read", 32'(rx_read), 0);
    chk("rst_level", 32'(level), 0);
    chk("rst_avail", 32'(cpu_avail), 0);
    chk("rst_full", 32'(full), 0);
    chk("rst_rts", 32'(rts_hold), 0);

    // Single byte, request held well past the acknowledge.
    hold_extra = 4;
    acks = ack_cnt;
    put(8'hA5);
    wait_idle();
    hold_extra = 1;
    chk("single_ack_count", ack_cnt - acks, 1);
    chk("single_level", 32'(level), 1);
    chk("single_avail", 32'(cpu_avail), 1);
    chk("single_data", 32'(cpu_data), 32'hA5);
    pop_n(1);
    chk("single_level_after_pop", 32'(level), 0);
    chk("single_avail_after_pop", 32'(cpu_avail), 0);

    // Fill, back-pressure, then drain.
    for (int i = 0; i < 16; i++) put(8'(i));
    wait_idle();
    chk("fill_full", 32'(full), 1);
    chk("fill_level", 32'(level), 16);
    chk("fill_rts", 32'(rts_hold), 32'(RTS_EN));
    acks = ack_cnt;
    put(8'h55);
    repeat (10) @(posedge clk);
    #1;
    chk("full_no_ack", ack_cnt - acks, 0);
    chk("full_level_hold", 32'(level), 16);
    pop_n(1);
    @(posedge clk); #1;
    chk("accept_after_pop", 32'(rx_read), 1);
    wait_idle();
    chk("refill_level", 32'(level), 16);
    pop_n(16);
    chk("drain_level", 32'(level), 0);
    chk("drain_full", 32'(full), 0);

    // Interleaved push/pop with wrap-around, occupancy kept at 5 or below.
    occ     = 0;
    max_lvl = 0;
    track   = 1'b1;
    for (int i = 0; i < 40; i++) begin
      put(8'(i * 37 + 11));
      wait_idle();
      occ++;
      if (occ >= 5 || $urandom_range(1, 0) == 1) begin
        pop_n(1);
        occ--;
      end
    end
    if (occ > 0) pop_n(occ);
    track = 1'b0;
    chk("wrap_max_level_le5", 32'(max_lvl <= 5), 1);
    chk("wrap_level_end", 32'(level), 0);

    // Simultaneous push and pop at level 3.
    put(8'hB0);
    put(8'hB1);
    put(8'hB2);
    wait_idle();
    chk("sim3_level_before", 32'(level), 3);
    direct_push(8'hB3, 1'b1);
    chk("sim3_level", 32'(level), 3);
    chk("sim3_head", 32'(cpu_data), 32'hB1);
    direct_release();
    pop_n(3);
    chk("sim3_drained", 32'(level), 0);

    // Simultaneous push and pop while empty: the pop is ignored.
    direct_push(8'hC7, 1'b1);
    chk("sim0_level", 32'(level), 1);
    chk("sim0_data", 32'(cpu_data), 32'hC7);
    direct_release();
    pop_n(1);
    pop_n(2);
    chk("empty_pop_ignored", 32'(level), 0);

    // Hysteresis on rts_hold.
    for (int i = 0; i < 11; i++) put(8'(8'h20 + i));
    wait_idle();
    chk("rts_at_11", 32'(rts_hold), 0);
    put(8'h2B);
    wait_idle();
    chk("rts_at_12", 32'(rts_hold), 32'(RTS_EN));
    pop_n(7);
    @(posedge clk); #1;
    chk("rts_at_5", 32'(rts_hold), 32'(RTS_EN));
    pop_n(1);
    chk("rts_at_4_same_cycle", 32'(rts_hold), 32'(RTS_EN));
    @(posedge clk); #1;
    chk("rts_at_4", 32'(rts_hold), 0);
    pop_n(4);
    chk("hyst_drained", 32'(level), 0);

    // Reset while in ACK with 7 bytes buffered; pending byte recaptured.
    for (int i = 0; i < 6; i++) put(8'(8'h60 + i));
    wait_idle();
    direct_push(8'h66, 1'b0);
    chk("pre_rst_level", 32'(level), 7);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    sb.delete();
    sb.push_back(8'h77);
    rx_data = 8'h77;
    chk("mid_rst_rx_read", 32'(rx_read), 0);
    chk("mid_rst_level", 32'(level), 0);
    chk("mid_rst_avail", 32'(cpu_avail), 0);
    chk("mid_rst_full", 32'(full), 0);
    chk("mid_rst_rts", 32'(rts_hold), 0);
    @(posedge clk); #1;
    chk("recapture_ack", 32'(rx_read), 1);
    chk("recapture_level", 32'(level), 1);
    chk("recapture_data", 32'(cpu_data), 32'h77);
    direct_release();
    pop_n(1);

    repeat (3) @(posedge clk);
    #1;
    chk("sb_drained", 32'(sb.size()), 0);
    chk("final_level", 32'(level), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
